// File: rtl/imem_loader_if.sv
`default_nettype none
// =====================================================================
// imem_loader_if : loader stream input and instruction-memory write port
// Rev 1.0
// =====================================================================
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // master: the stream source that also observes the memory writes
  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  // slave: the loader
  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// =====================================================================
// imem_loader : boot loader streaming length/words/checksum into imem,
//               holding the core in reset until a verified load completes
// Rev 1.0
// =====================================================================
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            core_rst,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [ADDR_W:0] word_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  localparam logic [31:0]       c_depth    = 32'(DEPTH);
  localparam logic [ADDR_W:0]   c_cnt_one  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_next;
  logic              r_in_ready;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_core_rst;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [ADDR_W:0]   r_word_count;
  logic [31:0]       r_checksum;
  logic [ADDR_W:0]   r_remaining;
  logic [ADDR_W-1:0] r_addr;

  logic w_accept;
  logic w_launch;
  logic w_streaming;

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_launch = start &&
                    ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) w_state_next = S_LEN;
      end
      S_LEN: begin
        if (w_accept) begin
          if (bus.in_data > c_depth)  w_state_next = S_ERROR;
          else if (bus.in_data == '0) w_state_next = S_CHECK;
          else                        w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept && (r_remaining == c_cnt_one)) w_state_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_accept) w_state_next = (bus.in_data == r_checksum) ? S_DONE : S_ERROR;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Status flags are derived from the next state so they move on the transition edge
  assign w_streaming = (w_state_next == S_LEN) || (w_state_next == S_LOAD) ||
                       (w_state_next == S_CHECK);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_core_rst   <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_word_count <= '0;
      r_checksum   <= '0;
      r_remaining  <= '0;
      r_addr       <= '0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= w_streaming;
      r_busy     <= w_streaming;
      r_done     <= (w_state_next == S_DONE);
      r_error    <= (w_state_next == S_ERROR);
      r_core_rst <= (w_state_next != S_DONE);
      r_imem_we  <= 1'b0;

      if (w_launch) begin
        r_word_count <= '0;
        r_checksum   <= '0;
        r_remaining  <= '0;
        r_addr       <= '0;
      end

      if (w_accept && (r_state == S_LEN) && (w_state_next == S_LOAD)) begin
        r_remaining <= bus.in_data[ADDR_W:0];
      end

      if (w_accept && (r_state == S_LOAD)) begin
        r_checksum   <= r_checksum + bus.in_data;
        r_remaining  <= r_remaining - c_cnt_one;
        r_imem_we    <= 1'b1;
        r_imem_addr  <= r_addr;
        r_imem_wdata <= bus.in_data;
        r_addr       <= r_addr + c_addr_one;
        r_word_count <= r_word_count + c_cnt_one;
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.imem_we    = r_imem_we;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.imem_wdata = r_imem_wdata;
  assign core_rst       = r_core_rst;
  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;
  assign word_count     = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// Testbench for imem_loader: stream-level reference model with randomized loads.
module tb_imem_loader;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  localparam logic [4:0] ST_IDLE = 5'b01000; // {in_ready, core_rst, busy, done, error}
  localparam logic [4:0] ST_BUSY = 5'b11100;
  localparam logic [4:0] ST_DONE = 5'b00010;
  localparam logic [4:0] ST_ERR  = 5'b01001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic core_rst, busy, done, error;
  logic [ADDR_W:0] word_count;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .core_rst  (core_rst),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [DEPTH];
  always @(posedge clk) if (bus.imem_we) mem[bus.imem_addr] <= bus.imem_wdata;

  int checks = 0;
  int failures = 0;

  logic [4:0] st;
  assign st = {bus.in_ready, core_rst, busy, done, error};

  // Drives one complete load and checks it against the stream-level model.
  task automatic run_stream(input logic [31:0] words[$], input int vmode,
                            input bit start_mid, input string tag);
    int n_data, n_consume, idx, nwr, cyc, first_bad;
    logic [31:0] n, sum;
    bit ok, v, acc, exp_we;
    logic [4:0] exp_st;

    n = words[0];
    sum = 32'd0;
    if (n > DEPTH) begin
      n_data = 0; n_consume = 1; ok = 1'b0;
    end else begin
      n_data = int'(n); n_consume = n_data + 2;
      for (int k = 1; k <= n_data; k++) sum += words[k];
      ok = (words[n_data+1] == sum);
    end

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({st, word_count} !== {ST_BUSY, 9'd0}) begin
      failures++;
      $display("FAIL %s start: status=%b wc=%0d expected status=%b wc=0", tag, st, word_count, ST_BUSY);
    end

    idx = 0; nwr = 0; cyc = 0;
    while (idx < n_consume && cyc < 4 * n_consume + 50) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      bus.in_valid = v;
      bus.in_data  = v ? words[idx] : $urandom;
      start = (start_mid && cyc == 3 && n_data >= 3);
      acc = v && bus.in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      exp_we = acc && idx >= 1 && idx <= n_data;
      checks++;
      if (bus.imem_we !== exp_we) begin
        failures++;
        $display("FAIL %s we cyc%0d: got %b expected %b", tag, cyc, bus.imem_we, exp_we);
      end
      if (exp_we) begin
        nwr++;
        checks++;
        if (bus.imem_addr !== ADDR_W'(idx - 1) || bus.imem_wdata !== words[idx]) begin
          failures++;
          $display("FAIL %s write: addr=%0d data=%h expected addr=%0d data=%h",
                   tag, bus.imem_addr, bus.imem_wdata, idx - 1, words[idx]);
        end
      end
      checks++;
      if (word_count !== (ADDR_W+1)'(nwr)) begin
        failures++;
        $display("FAIL %s word_count: got %0d expected %0d", tag, word_count, nwr);
      end
      if (acc) idx++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (idx < n_consume) begin
      failures++;
      $display("FAIL %s timeout: consumed %0d expected %0d", tag, idx, n_consume);
    end

    exp_st = ok ? ST_DONE : ST_ERR;
    checks++;
    if ({st, word_count} !== {exp_st, 9'(n_data)}) begin
      failures++;
      $display("FAIL %s final: status=%b wc=%0d expected status=%b wc=%0d",
               tag, st, word_count, exp_st, n_data);
    end

    // Words offered while not ready must be ignored.
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      @(posedge clk); #1;
      checks++;
      if ({bus.imem_we, st, word_count} !== {1'b0, exp_st, 9'(n_data)}) begin
        failures++;
        $display("FAIL %s hold: we=%b status=%b wc=%0d expected we=0 status=%b wc=%0d",
                 tag, bus.imem_we, st, word_count, exp_st, n_data);
      end
    end
    bus.in_valid = 1'b0;

    first_bad = -1;
    for (int a = 0; a < n_data; a++)
      if (first_bad < 0 && mem[a] !== words[a+1]) first_bad = a;
    checks++;
    if (first_bad >= 0) begin
      failures++;
      $display("FAIL %s memory: addr %0d holds %h expected %h",
               tag, first_bad, mem[first_bad], words[first_bad+1]);
    end
  endtask

  task automatic make_stream(input int n, input bit corrupt, output logic [31:0] q[$]);
    logic [31:0] sum, w;
    sum = 32'd0;
    q.delete();
    q.push_back(32'(n));
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      sum += w;
      q.push_back(w);
    end
    q.push_back(corrupt ? sum ^ (32'd1 << $urandom_range(0, 31)) : sum);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({st, word_count, bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {ST_IDLE, 9'd0, 1'b0, 8'd0, 32'd0}) begin
      failures++;
      $display("FAIL reset: status=%b wc=%0d we=%b addr=%0d wdata=%h expected status=%b all zero",
               st, word_count, bus.imem_we, bus.imem_addr, bus.imem_wdata, ST_IDLE);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({st, word_count, bus.imem_we} !== {ST_IDLE, 9'd0, 1'b0}) begin
      failures++;
      $display("FAIL idle_valid: status=%b wc=%0d we=%b expected status=%b wc=0 we=0",
               st, word_count, bus.imem_we, ST_IDLE);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_directed_done();
    logic [31:0] q[$];
    q = '{32'd2, 32'h01900113, 32'h00A10113, 32'h02310226};
    run_stream(q, 0, 1'b0, "directed_done");
  endtask

  task automatic test_bad_checksum();
    logic [31:0] q[$];
    q = '{32'd2, 32'h01900113, 32'h00A10113, 32'h02310227};
    run_stream(q, 0, 1'b0, "bad_checksum");
  endtask

  task automatic test_oversize();
    logic [31:0] q[$];
    q = '{32'd257};
    run_stream(q, 0, 1'b0, "oversize");
    q = '{32'd0, 32'd0};
    run_stream(q, 0, 1'b0, "empty_load");
  endtask

  task automatic test_toggle_valid();
    logic [31:0] q[$];
    make_stream(4, 1'b0, q);
    run_stream(q, 1, 1'b0, "toggle_valid");
  endtask

  task automatic test_full_depth();
    logic [31:0] q[$];
    make_stream(DEPTH, 1'b0, q);
    run_stream(q, 2, 1'b0, "full_depth");
  endtask

  task automatic test_start_ignored_and_restart();
    logic [31:0] q[$];
    make_stream(6, 1'b0, q);
    run_stream(q, 0, 1'b1, "start_in_load");
    make_stream(3, 1'b0, q);
    run_stream(q, 0, 1'b0, "restart_from_done");
  endtask

  task automatic test_reset_midload();
    logic [31:0] w0, w1;
    w0 = $urandom;
    w1 = $urandom;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'd5;
    @(posedge clk); #1;
    bus.in_data = w0;
    @(posedge clk); #1;
    bus.in_data = w1;
    @(posedge clk); #1;
    checks++;
    if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 8'd1, w1}) begin
      failures++;
      $display("FAIL midload_write: we=%b addr=%0d data=%h expected we=1 addr=1 data=%h",
               bus.imem_we, bus.imem_addr, bus.imem_wdata, w1);
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checks++;
    if ({st, word_count} !== {ST_IDLE, 9'd0}) begin
      failures++;
      $display("FAIL midload_reset: status=%b wc=%0d expected status=%b wc=0", st, word_count, ST_IDLE);
    end
    @(posedge clk); #1;
    checks++;
    if (mem[0] !== w0 || mem[1] !== w1) begin
      failures++;
      $display("FAIL midload_mem: mem0=%h mem1=%h expected %h %h", mem[0], mem[1], w0, w1);
    end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    int n, r;
    for (int t = 0; t < 14; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) n = DEPTH + 1 + $urandom_range(0, 1000);
      else        n = $urandom_range(0, 20);
      make_stream(n, $urandom_range(0, 3) == 0, q);
      run_stream(q, $urandom_range(0, 2), $urandom_range(0, 1) == 1, "random");
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    test_reset();
    test_directed_done();
    test_bad_checksum();
    test_oversize();
    test_toggle_valid();
    test_start_ignored_and_restart();
    test_reset_midload();
    test_full_depth();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
